uart_tx_fifo: RTL

//  Byte FIFO sitting directly upstream of the UART transmitter. Accepts bytes

---
 rtl/uart_tx_fifo_if.sv | 28 ++
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the CPU-side writer, the TX FIFO and the UART transmitter.
// The master side pushes bytes and provides the transmitter busy flag.
// The slave side is the FIFO, which reports status and drives the transmitter strobes.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              clear_ovf;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic [7:0]        tx_bus;
  logic              tx_load;
  logic              tx_send;
  logic              tx_busy;

  modport master (
    output wr_en, wr_data, clear_ovf, tx_busy,
    input  full, empty, count, overflow, tx_bus, tx_load, tx_send
  );

  modport slave (
    input  wr_en, wr_data, clear_ovf, tx_busy,
    output full, empty, count, overflow, tx_bus, tx_load, tx_send
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter.
// Software can queue a burst of bytes here without polling the transmitter.
// The launch FSM hands the transmitter one byte at a time and waits for its
// busy flag to rise and then fall before it launches the next byte.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           reset,
  uart_tx_fifo_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              strobe_q, strobe_d;
  logic [7:0]        txBus_q, txBus_d;
  logic              full, empty, push, pop;

  // Status comes from the registered count only, so it stays glitch-free.
  assign full  = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty = (count_q == '0);

  // A pop that happens in the same cycle frees a slot, so a push to a full FIFO can still be accepted.
  assign push  = bus.wr_en && (!full || pop);

  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.count    = count_q;
  assign bus.overflow = overflow_q;
  assign bus.tx_bus   = txBus_q;
  assign bus.tx_load  = strobe_q;
  assign bus.tx_send  = strobe_q;

  // State register for the launch FSM.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic. ARM waits for busy to rise, and WAIT waits for busy to fall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!empty && !bus.tx_busy) state_d = S_ARM;
      S_ARM:   if (bus.tx_busy)            state_d = S_WAIT;
      S_WAIT:  if (!bus.tx_busy)           state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic. A launch pops the head byte and raises both strobes for the next cycle only.
  always_comb begin
    pop      = 1'b0;
    strobe_d = 1'b0;
    txBus_d  = txBus_q;
    if (state_q == S_IDLE && !empty && !bus.tx_busy) begin
      pop      = 1'b1;
      strobe_d = 1'b1;
      txBus_d  = mem_q[rdPtr_q];
    end
  end

  // Next pointer, count and overflow values. When clear_ovf and a dropped push coincide, the set wins.
  always_comb begin
    rdPtr_d    = pop  ? rdPtr_q + ADDR_W'(1) : rdPtr_q;
    wrPtr_d    = push ? wrPtr_q + ADDR_W'(1) : wrPtr_q;
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + (ADDR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (ADDR_W+1)'(1);
    overflow_d = overflow_q;
    if (bus.wr_en && !push) overflow_d = 1'b1;
    else if (bus.clear_ovf) overflow_d = 1'b0;
  end

  // Datapath registers. Reset discards queued bytes and any pending strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      strobe_q   <= 1'b0;
      txBus_q    <= 8'h00;
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      strobe_q   <= strobe_d;
      txBus_q    <= txBus_d;
    end
  end

  // Storage array. It has no reset because the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wrPtr_q] <= bus.wr_data;
  end

endmodule
